// File: rtl/comp_minmax_stream.sv
// comp_minmax_stream: streaming signed/unsigned running min/max with element indices
module comp_minmax_stream #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_energy,
    input  logic             i_start,
    input  logic             i_mode_signed,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_last,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_min,
    output logic [WIDTH-1:0] o_out_max,
    output logic [IDX_W-1:0] o_out_min_idx,
    output logic [IDX_W-1:0] o_out_max_idx,
    output logic [IDX_W-1:0] o_out_count,
    output logic             o_out_ovf,
    output logic             o_busy
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t           r_state;
    logic             r_signed;
    logic             r_first;
    logic             r_full;
    logic             r_ovf;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_min_idx;
    logic [IDX_W-1:0] r_max_idx;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH:0]   w_dmin;
    logic [WIDTH:0]   w_dmax;
    logic             w_lt_min;
    logic             w_gt_max;
    logic             w_sat;
    assign o_in_ready    = i_energy && r_state == ACC;
    assign o_out_valid   = r_state == DONE;
    assign o_busy        = r_state != IDLE;
    assign o_out_min     = r_min;
    assign o_out_max     = r_max;
    assign o_out_min_idx = r_min_idx;
    assign o_out_max_idx = r_max_idx;
    assign o_out_count   = r_cnt;
    assign o_out_ovf     = r_ovf;
    assign w_sat         = &r_cnt;
    // one extra bit, sign-filled in signed mode, so the difference MSB is exactly a<b
    assign w_dmin   = {r_signed & i_in_data[WIDTH-1], i_in_data} - {r_signed & r_min[WIDTH-1], r_min};
    assign w_dmax   = {r_signed & r_max[WIDTH-1], r_max} - {r_signed & i_in_data[WIDTH-1], i_in_data};
    assign w_lt_min = w_dmin[WIDTH];
    assign w_gt_max = w_dmax[WIDTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_signed  <= 1'b0;
            r_first   <= 1'b0;
            r_full    <= 1'b0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_min_idx <= '0;
            r_max_idx <= '0;
            r_min     <= '0;
            r_max     <= '0;
        end else if (i_energy) begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_state  <= ACC;
                    r_signed <= i_mode_signed;
                    r_first  <= 1'b1;
                    r_full   <= 1'b0;
                    r_ovf    <= 1'b0;
                    r_cnt    <= '0;
                end
                ACC: if (i_in_valid) begin
                    r_first <= 1'b0;
                    if (r_first || w_lt_min) begin
                        r_min     <= i_in_data;
                        r_min_idx <= r_cnt;
                    end
                    if (r_first || w_gt_max) begin
                        r_max     <= i_in_data;
                        r_max_idx <= r_cnt;
                    end
                    // r_full marks that the element at the saturated index was consumed
                    r_cnt   <= w_sat ? r_cnt : r_cnt + 1'b1;
                    r_full  <= r_full | w_sat;
                    r_ovf   <= r_ovf | r_full;
                    if (i_in_last) r_state <= DONE;
                end
                DONE: if (i_out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_comp_minmax_stream.sv
// tb_comp_minmax_stream: scoreboard bench for the streaming min/max block
module tb_comp_minmax_stream;
    typedef struct packed {
        logic [15:0] mn;
        logic [15:0] mx;
        logic [7:0]  mni;
        logic [7:0]  mxi;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;
    logic clk = 0, rst = 1, energy = 1, start = 0, mode = 0;
    logic in_valid = 0, in_last = 0, out_ready = 0;
    logic [15:0] in_data = 0;
    logic in_ready, out_valid, busy, ovf;
    logic [15:0] mn, mx;
    logic [7:0] mni, mxi, cnt;
    logic d2_in_ready, d2_out_valid, d2_busy, d2_ovf;
    logic [15:0] d2_mn, d2_mx;
    logic [1:0] d2_mni, d2_mxi, d2_cnt;
    int total = 0, bad = 0, pushed = 0, got = 0;
    exp_t sb[$];
    always #5 clk = ~clk;
    comp_minmax_stream dut (
        .clk(clk), .rst(rst), .i_energy(energy), .i_start(start), .i_mode_signed(mode),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data), .i_in_last(in_last),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_min(mn), .o_out_max(mx),
        .o_out_min_idx(mni), .o_out_max_idx(mxi), .o_out_count(cnt), .o_out_ovf(ovf), .o_busy(busy)
    );
    comp_minmax_stream #(.WIDTH(16), .IDX_W(2)) dut2 (
        .clk(clk), .rst(rst), .i_energy(energy), .i_start(start), .i_mode_signed(mode),
        .i_in_valid(in_valid), .o_in_ready(d2_in_ready), .i_in_data(in_data), .i_in_last(in_last),
        .o_out_valid(d2_out_valid), .i_out_ready(out_ready), .o_out_min(d2_mn), .o_out_max(d2_mx),
        .o_out_min_idx(d2_mni), .o_out_max_idx(d2_mxi), .o_out_count(d2_cnt), .o_out_ovf(d2_ovf), .o_busy(d2_busy)
    );
    // reference: signed order is unsigned order with the MSB flipped
    function automatic exp_t model(input logic [15:0] d[$], input logic s);
        exp_t e;
        logic [15:0] k, kmn, kmx;
        int n;
        n = d.size();
        e = '0;
        kmn = 0;
        kmx = 0;
        for (int i = 0; i < n; i++) begin
            k = s ? d[i] ^ 16'h8000 : d[i];
            if (i == 0 || k < kmn) begin kmn = k; e.mn = d[i]; e.mni = i > 255 ? 8'd255 : 8'(i); end
            if (i == 0 || k > kmx) begin kmx = k; e.mx = d[i]; e.mxi = i > 255 ? 8'd255 : 8'(i); end
        end
        e.cnt = n > 255 ? 8'd255 : 8'(n);
        e.ovf = n > 256;
        return e;
    endfunction
    always @(negedge clk) begin
        if (!rst && energy && out_ready && out_valid) begin
            exp_t e, a;
            a = '{mn, mx, mni, mxi, cnt, ovf};
            got++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL result_unexpected got min=%h max=%h with empty scoreboard", mn, mx);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL result got min=%h/%0d max=%h/%0d cnt=%0d ovf=%b want min=%h/%0d max=%h/%0d cnt=%0d ovf=%b",
                             mn, mni, mx, mxi, cnt, ovf, e.mn, e.mni, e.mx, e.mxi, e.cnt, e.ovf);
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_start(input logic s);
        mode = s;
        start = 1;
        tick();
        start = 0;
        mode = ~s;
    endtask
    task automatic send(input logic [15:0] d, input logic l);
        bit ok = 0;
        in_valid = 1;
        in_data = d;
        in_last = l;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 0;
        in_last = 0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout in_ready=%b want 1", in_ready);
        end
    endtask
    task automatic collect();
        int n = 0;
        out_ready = 1;
        while (!out_valid && n < 20) begin tick(); n++; end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL collect_timeout out_valid=%b want 1", out_valid);
        end else tick();
        out_ready = 0;
    endtask
    task automatic frame(input logic [15:0] d[$], input logic s);
        sb.push_back(model(d, s));
        pushed++;
        do_start(s);
        foreach (d[i]) send(d[i], i == d.size() - 1);
    endtask
    task automatic test_reset();
        repeat (3) tick();
        total++;
        if ({busy, in_ready, out_valid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl got %b want 000", {busy, in_ready, out_valid});
        end
        total++;
        if ({mn, mx, mni, mxi, cnt, ovf} !== '0) begin
            bad++;
            $display("FAIL reset_data got %h want 0", {mn, mx, mni, mxi, cnt, ovf});
        end
        rst = 0;
        tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask
    task automatic test_unsigned();
        frame('{16'h0005, 16'hFFFF, 16'h0003, 16'h0007}, 1'b0);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL latency got out_valid=%b want 1", out_valid); end
        collect();
        total++;
        if ({mn, mni, mx, mxi, cnt} !== {16'h0003, 8'd2, 16'hFFFF, 8'd1, 8'd4}) begin
            bad++;
            $display("FAIL unsigned got %h/%0d %h/%0d cnt=%0d want 0003/2 ffff/1 cnt=4", mn, mni, mx, mxi, cnt);
        end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL valid_drop got %b want 0", out_valid); end
    endtask
    task automatic test_signed();
        frame('{16'h0005, 16'hFFFF, 16'h0003, 16'h0007}, 1'b1);
        collect();
        total++;
        if ({mn, mni, mx, mxi} !== {16'hFFFF, 8'd1, 16'h0007, 8'd3}) begin
            bad++;
            $display("FAIL signed got %h/%0d %h/%0d want ffff/1 0007/3", mn, mni, mx, mxi);
        end
        frame('{16'h7FFF, 16'h8000}, 1'b1);
        collect();
        total++;
        if ({mn, mx} !== {16'h8000, 16'h7FFF}) begin
            bad++;
            $display("FAIL signed_ovf got min=%h max=%h want 8000 7fff", mn, mx);
        end
    endtask
    task automatic test_ties();
        frame('{16'h0004, 16'h0004, 16'h0004}, 1'b0);
        collect();
        total++;
        if ({mni, mxi} !== 16'h0000) begin bad++; $display("FAIL ties got %0d %0d want 0 0", mni, mxi); end
        frame('{16'h1234}, 1'b0);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL single_latency got %b want 1", out_valid); end
        collect();
        total++;
        if ({mn, mx, mni, mxi, cnt} !== {16'h1234, 16'h1234, 8'd0, 8'd0, 8'd1}) begin
            bad++;
            $display("FAIL single got %h %h %0d %0d %0d want 1234 1234 0 0 1", mn, mx, mni, mxi, cnt);
        end
    endtask
    task automatic test_handshake();
        sb.push_back(model('{16'd10, 16'd20, 16'd5, 16'd30}, 1'b0));
        pushed++;
        do_start(1'b0);
        send(16'd10, 0);
        repeat (2) tick();
        send(16'd20, 0);
        energy = 0;
        in_valid = 1;
        in_data = 0;
        in_last = 1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL freeze_ready got %b want 0", in_ready); end
            tick();
        end
        total++;
        if ({busy, cnt, mn} !== {1'b1, 8'd2, 16'd10}) begin
            bad++;
            $display("FAIL freeze_state got busy=%b cnt=%0d min=%0d want 1 2 10", busy, cnt, mn);
        end
        energy = 1;
        in_valid = 0;
        in_last = 0;
        tick();
        send(16'd5, 0);
        tick();
        send(16'd30, 1);
        start = 1;
        repeat (5) tick();
        start = 0;
        total++;
        if ({out_valid, busy, mn, mni, mx, mxi} !== {2'b11, 16'd5, 8'd2, 16'd30, 8'd3}) begin
            bad++;
            $display("FAIL done_hold got v=%b b=%b %0d/%0d %0d/%0d want 1 1 5/2 30/3", out_valid, busy, mn, mni, mx, mxi);
        end
        out_ready = 1;
        energy = 0;
        repeat (2) tick();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL freeze_done got %b want 1", out_valid); end
        energy = 1;
        collect();
        total++;
        if ({out_valid, busy} !== 2'b00) begin bad++; $display("FAIL exit_done got %b want 00", {out_valid, busy}); end
    endtask
    task automatic test_ovf();
        frame('{16'd1, 16'd2, 16'd3, 16'd4}, 1'b0);
        collect();
        total++;
        if ({d2_cnt, d2_ovf, d2_mxi} !== {2'd3, 1'b0, 2'd3}) begin
            bad++;
            $display("FAIL idx2_full got cnt=%0d ovf=%b maxidx=%0d want 3 0 3", d2_cnt, d2_ovf, d2_mxi);
        end
        frame('{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4}, 1'b0);
        total++;
        if (d2_out_valid !== 1'b1) begin bad++; $display("FAIL idx2_valid got %b want 1", d2_out_valid); end
        collect();
        total++;
        if ({d2_cnt, d2_ovf, d2_mn, d2_mni, d2_mx, d2_mxi} !== {2'd3, 1'b1, 16'd4, 2'd3, 16'd9, 2'd0}) begin
            bad++;
            $display("FAIL idx2_ovf got cnt=%0d ovf=%b %0d/%0d %0d/%0d want 3 1 4/3 9/0",
                     d2_cnt, d2_ovf, d2_mn, d2_mni, d2_mx, d2_mxi);
        end
    endtask
    task automatic test_saturate();
        logic [15:0] q[$];
        for (int n = 256; n <= 257; n++) begin
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(16'($urandom));
            frame(q, n[0]);
            collect();
            total++;
            if ({cnt, ovf} !== {8'd255, n == 257}) begin
                bad++;
                $display("FAIL sat_%0d got cnt=%0d ovf=%b want 255 %b", n, cnt, ovf, n == 257);
            end
        end
    endtask
    task automatic test_reset_mid();
        do_start(1'b0);
        send(16'd100, 0);
        send(16'd200, 0);
        rst = 1;
        tick();
        rst = 0;
        total++;
        if ({busy, in_ready, out_valid, mn, mx, mni, mxi, cnt, ovf} !== '0) begin
            bad++;
            $display("FAIL reset_mid got b=%b r=%b v=%b min=%h max=%h cnt=%0d want all 0", busy, in_ready, out_valid, mn, mx, cnt);
        end
        frame('{16'd3, 16'd1, 16'd2}, 1'b0);
        collect();
    endtask
    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_ties();
        test_handshake();
        test_ovf();
        test_saturate();
        test_reset_mid();
        repeat (2) tick();
        total++;
        if (got !== pushed || sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard got %0d results want %0d (left %0d)", got, pushed, sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
